// File: rtl/ps2_keyboard_receiver_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_keyboard_receiver_pkg;

  // Receiver frame states (2-bit encoding kept compatible with older users)
  localparam logic [1:0] PS2_IDLE   = 2'd0;
  localparam logic [1:0] PS2_DATA   = 2'd1;
  localparam logic [1:0] PS2_PARITY = 2'd2;
  localparam logic [1:0] PS2_STOP   = 2'd3;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // One-cycle event strobes produced when a frame closes or is aborted
  typedef struct packed {
    logic push;
    logic parity_error;
    logic framing_error;
    logic timeout_error;
  } ps2_evt_t;

  // Odd parity holds when the nine bits D0..D7,P contain an odd number of ones
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_input_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised line after it has held a new level for
// FILTER_LEN consecutive clocks. Shorter pulses are dropped.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: count consecutive disagreeing cycles, flip level at the limit
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; idle PS/2 lines are high, so everything resets to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host receiver: filters both lines, deframes 11-bit
// frames on filtered falling clock edges, and reports scancodes to the
// scancode FIFO along with parity, framing, timeout and overflow faults.
module ps2_keyboard_receiver
  import ps2_keyboard_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       fifo_full,
  input  logic       overflow_clear,
  output logic       push,
  output logic [7:0] push_data,
  output logic       parity_error,
  output logic       framing_error,
  output logic       timeout_error,
  output logic       overflow,
  output logic       busy
);
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TC_TERM = TCW'(TIMEOUT_CYCLES - 1);

  logic fclk, fdat, fall;

  logic                     fclk_prev_q, fclk_prev_d;
  logic [1:0]               state_q, state_d;
  logic [2:0]               bitcnt_q, bitcnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_ok_q, par_ok_d;
  logic [TCW-1:0]           tcnt_q, tcnt_d;
  logic [7:0]               push_data_q, push_data_d;
  logic                     overflow_q, overflow_d;
  ps2_evt_t                 evt_q, evt_d;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk (clk),
    .rst (reset),
    .din (ps2_clk),
    .dout(fclk)
  );

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk (clk),
    .rst (reset),
    .din (ps2_dat),
    .dout(fdat)
  );

  assign fclk_prev_d = fclk;
  assign fall        = fclk_prev_q & ~fclk;

  // Frame FSM, inter-edge timeout and overflow bookkeeping
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    tcnt_d      = tcnt_q;
    push_data_d = push_data_q;
    evt_d       = '0;
    overflow_d  = overflow_q;
    if (overflow_clear) overflow_d = 1'b0;

    // Timeout only watches gaps inside a frame; a fall on the terminal
    // count wins because the abort branch requires no fall.
    if (state_q == PS2_IDLE || fall) begin
      tcnt_d = '0;
    end else if (tcnt_q == TC_TERM) begin
      evt_d.timeout_error = 1'b1;
      state_d             = PS2_IDLE;
      bitcnt_d            = '0;
      shift_d             = '0;
      tcnt_d              = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end

    if (fall) begin
      case (state_q)
        PS2_IDLE: begin
          if (!fdat) begin
            state_d  = PS2_DATA;
            bitcnt_d = '0;
            shift_d  = '0;
          end
        end
        PS2_DATA: begin
          shift_d[bitcnt_q] = fdat;
          bitcnt_d          = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PS2_PARITY;
        end
        PS2_PARITY: begin
          par_ok_d = ps2_parity_ok(shift_q, fdat);
          state_d  = PS2_STOP;
        end
        default: begin
          state_d = PS2_IDLE;
          if (!fdat) begin
            evt_d.framing_error = 1'b1;
          end else if (!par_ok_q) begin
            evt_d.parity_error = 1'b1;
          end else if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            evt_d.push  = 1'b1;
            push_data_d = shift_q;
          end
        end
      endcase
    end
  end

  // All receiver state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fclk_prev_q <= 1'b1;
      state_q     <= PS2_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tcnt_q      <= '0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
      evt_q       <= '0;
    end else begin
      fclk_prev_q <= fclk_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tcnt_q      <= tcnt_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
      evt_q       <= evt_d;
    end
  end

  assign push          = evt_q.push;
  assign push_data     = push_data_q;
  assign parity_error  = evt_q.parity_error;
  assign framing_error = evt_q.framing_error;
  assign timeout_error = evt_q.timeout_error;
  assign overflow      = overflow_q;
  assign busy          = (state_q != PS2_IDLE);

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: a vector table of
// frame scenarios, hand-written corner sequences, and random frames
// judged by a frame-level reference model.
module tb_ps2_keyboard_receiver;
  localparam int FL   = 4;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_dat, fifo_full, overflow_clear;
  logic       push, parity_error, framing_error, timeout_error, overflow, busy;
  logic [7:0] push_data;

  int n_tests = 0;
  int n_fail  = 0;

  int         n_push = 0, n_perr = 0, n_ferr = 0, n_tout = 0, n_ovf_cyc = 0;
  logic [7:0] last_data = 8'h00;

  always #5 clk = ~clk;

  ps2_keyboard_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_dat       (ps2_dat),
    .fifo_full     (fifo_full),
    .overflow_clear(overflow_clear),
    .push          (push),
    .push_data     (push_data),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .timeout_error (timeout_error),
    .overflow      (overflow),
    .busy          (busy)
  );

  // Event monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (!reset) begin
      if (push) begin
        n_push    <= n_push + 1;
        last_data <= push_data;
      end
      if (parity_error)  n_perr    <= n_perr + 1;
      if (framing_error) n_ferr    <= n_ferr + 1;
      if (timeout_error) n_tout    <= n_tout + 1;
      if (overflow)      n_ovf_cyc <= n_ovf_cyc + 1;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop;
    logic       full;
    logic       glitch;
    logic       e_push;
    logic       e_perr;
    logic       e_ferr;
    logic       e_ovf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic flip, input logic stop);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = d;
    f[9]    = ~(^d) ^ flip;
    f[10]   = stop;
    return f;
  endfunction

  // Device-side driver: data changes while clock is high, host samples on fall
  task automatic send_bits(input logic [10:0] bits, input int nb, input int hi,
                           input int lo, input logic glitch);
    for (int i = 0; i < nb; i++) begin
      ps2_dat = bits[i];
      if (glitch && hi >= 10) begin
        tick(3);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(hi - 6);
      end else begin
        tick(hi);
      end
      ps2_clk = 1'b0;
      tick(lo);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic clear_ovf();
    overflow_clear = 1'b1;
    tick(1);
    overflow_clear = 1'b0;
    tick(1);
  endtask

  task automatic do_frame(input string nm, input logic [7:0] d, input logic flip,
                          input logic stop, input logic full, input logic glitch,
                          input int hi, input int lo, input logic e_push,
                          input logic e_perr, input logic e_ferr, input logic e_ovf);
    int p0, pe0, fe0, to0;
    p0 = n_push; pe0 = n_perr; fe0 = n_ferr; to0 = n_tout;
    fifo_full = full;
    send_bits(frame(d, flip, stop), 11, hi, lo, glitch);
    tick(HALF + FL + 8);
    fifo_full = 1'b0;
    check({nm, "/push"}, 32'(n_push - p0), 32'(e_push));
    if (e_push) check({nm, "/data"}, 32'(last_data), 32'(d));
    check({nm, "/perr"}, 32'(n_perr - pe0), 32'(e_perr));
    check({nm, "/ferr"}, 32'(n_ferr - fe0), 32'(e_ferr));
    check({nm, "/tout"}, 32'(n_tout - to0), 32'd0);
    check({nm, "/ovf"},  32'(overflow), 32'(e_ovf));
    check({nm, "/busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vt[8];

  initial begin
    int p0, to0, o0;
    logic [7:0] d;
    logic       flip, stop, full, bad_par;

    vt[0] = '{8'h1C, 0, 1, 0, 0, 1, 0, 0, 0};
    vt[1] = '{8'h1C, 1, 1, 0, 0, 0, 1, 0, 0};
    vt[2] = '{8'hF0, 0, 1, 0, 0, 1, 0, 0, 0};
    vt[3] = '{8'h1C, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[4] = '{8'h1C, 1, 0, 0, 0, 0, 0, 1, 0};
    vt[5] = '{8'h1C, 0, 1, 0, 1, 1, 0, 0, 0};
    vt[6] = '{8'h29, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[7] = '{8'h29, 0, 1, 0, 0, 1, 0, 0, 0};

    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    fifo_full = 1'b0; overflow_clear = 1'b0;
    tick(3);
    check("rst/push", 32'(push), 0);
    check("rst/data", 32'(push_data), 0);
    check("rst/errs", 32'({parity_error, framing_error, timeout_error}), 0);
    check("rst/ovf",  32'(overflow), 0);
    check("rst/busy", 32'(busy), 0);
    reset = 1'b0;
    tick(10);
    check("rst/quiet", 32'(n_push + n_perr + n_ferr + n_tout), 0);

    // Idle glitch with data low: would look like a start bit if accepted
    ps2_dat = 1'b0; ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(12);
    check("idle_glitch/busy", 32'(busy), 0);
    ps2_dat = 1'b1; tick(10);

    for (int i = 0; i < 8; i++) begin
      do_frame($sformatf("vec%0d", i), vt[i].data, vt[i].flip, vt[i].stop, vt[i].full,
               vt[i].glitch, HALF, HALF, vt[i].e_push, vt[i].e_perr, vt[i].e_ferr, vt[i].e_ovf);
      clear_ovf();
      check($sformatf("vec%0d/ovf_clr", i), 32'(overflow), 0);
    end

    // Partial frame then silence: exactly one timeout, then recovery
    p0 = n_push; to0 = n_tout;
    send_bits(frame(8'h5A, 0, 1), 5, HALF, HALF, 0);
    tick(TO + 100);
    check("tmo/count", 32'(n_tout - to0), 1);
    check("tmo/busy",  32'(busy), 0);
    check("tmo/push",  32'(n_push - p0), 0);
    do_frame("tmo_next", 8'h5A, 0, 1, 0, 0, HALF, HALF, 1, 0, 0, 0);

    // Fall interval equal to TIMEOUT_CYCLES lands on the terminal count
    do_frame("tmo_edge", 8'hA7, 0, 1, 0, 0, TO / 2, TO / 2, 1, 0, 0, 0);

    // One cycle longer aborts; the late fall sees D0=1 in idle and is ignored
    to0 = n_tout;
    send_bits(11'b000_0000_0010, 2, TO / 2 + 1, TO / 2, 0);
    tick(TO + 50);
    check("tmo_over/count", 32'(n_tout - to0), 1);
    check("tmo_over/busy",  32'(busy), 0);

    // Clear held during an overflow event: set wins for one cycle
    o0 = n_ovf_cyc; p0 = n_push;
    overflow_clear = 1'b1; fifo_full = 1'b1;
    send_bits(frame(8'h29, 0, 1), 11, HALF, HALF, 0);
    tick(HALF + FL + 8);
    overflow_clear = 1'b0; fifo_full = 1'b0;
    tick(2);
    check("ovf_setwins/cycles", 32'(n_ovf_cyc - o0), 1);
    check("ovf_setwins/push",   32'(n_push - p0), 0);

    // Sticky overflow does not block later pushes
    do_frame("ovf_set",  8'h29, 0, 1, 1, 0, HALF, HALF, 0, 0, 0, 1);
    do_frame("ovf_pass", 8'h66, 0, 1, 0, 0, HALF, HALF, 1, 0, 0, 1);
    clear_ovf();

    // Reset after bit 5 of a frame
    send_bits(frame(8'hC3, 0, 1), 6, HALF, HALF, 0);
    reset = 1'b1;
    tick(2);
    check("midrst/outs", 32'({push, parity_error, framing_error, timeout_error, overflow, busy}), 0);
    check("midrst/data", 32'(push_data), 0);
    reset = 1'b0;
    p0 = n_push; to0 = n_tout;
    tick(TO + 20);
    check("midrst/quiet", 32'(n_push - p0 + n_tout - to0 + 0), 0);
    do_frame("midrst_next", 8'h3C, 0, 1, 0, 0, HALF, HALF, 1, 0, 0, 0);

    // Random frames against the frame-level model
    for (int i = 0; i < 20; i++) begin
      d       = 8'($urandom_range(0, 255));
      flip    = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 7) != 0);
      full    = ($urandom_range(0, 3) == 0);
      bad_par = ($countones({d, ~(^d) ^ flip}) % 2) == 0;
      do_frame($sformatf("rnd%0d", i), d, flip, stop, full, 1'($urandom_range(0, 1)),
               HALF, HALF,
               stop && !bad_par && !full,
               stop && bad_par,
               !stop,
               stop && !bad_par && full);
      clear_ovf();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
